// File: rtl/ifetch_idecode.sv
// Instruction fetch stage plus IF/ID pipeline latch for the pipelined MIPS core.
// Latency: an icache hit in cycle N is presented to decode in cycle N+1; redirects cost one bubble.
// Backpressure: stall_for_data freezes all state; hazard_stall holds pc and IF/ID and drops the hit word.
//
// Ports:
//   CLK, RST             core clock, synchronous active-high reset
//   ihit, imemload       icache hit strobe and returned instruction word
//   stall_for_data       global data-memory stall (also freezes ID/EX)
//   hazard_stall         load-use hold from the hazard unit
//   redirect, redirect_pc  EX-resolved branch/jump target
//   imemREN, imemaddr    icache read enable and address (the pc register)
//   instr_out, pcplusfour_out, valid_out  IF/ID latch contents to decode
//   fetch_cnt            number of valid instructions latched into IF/ID
module ifetch_idecode #(
  parameter logic [31:0] PC_INIT   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall_for_data,
  input  logic        hazard_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instr_out,
  output logic [31:0] pcplusfour_out,
  output logic        valid_out,
  output logic [31:0] fetch_cnt
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pcplusfour;
  logic        r_valid;
  logic        r_fetch_halted;
  logic [31:0] r_fetch_cnt;

  logic [31:0] w_pc_plus4;
  logic        w_is_halt;

  // Both wrap modulo 2^32 by construction of the 32-bit adders.
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_is_halt  = (imemload == HALT_WORD);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc           <= PC_INIT;
      r_instr        <= 32'd0;
      r_pcplusfour   <= 32'd0;
      r_valid        <= 1'b0;
      r_fetch_halted <= 1'b0;
      r_fetch_cnt    <= 32'd0;
    end else if (stall_for_data) begin
      // Whole front end frozen; EX keeps any redirect asserted until the stall drops.
    end else if (redirect) begin
      // Wrong-path word (including a halt word) is squashed; fetch restarts at the target.
      r_pc           <= redirect_pc;
      r_instr        <= 32'd0;
      r_pcplusfour   <= 32'd0;
      r_valid        <= 1'b0;
      r_fetch_halted <= 1'b0;
    end else if (hazard_stall) begin
      // Decode must keep its instruction; the hit word is dropped and refetched from the held pc.
    end else if (ihit && !r_fetch_halted) begin
      r_instr      <= imemload;
      r_pcplusfour <= w_pc_plus4;
      r_valid      <= 1'b1;
      r_fetch_cnt  <= r_fetch_cnt + 32'd1;
      if (w_is_halt) begin
        r_fetch_halted <= 1'b1;
      end else begin
        r_pc <= w_pc_plus4;
      end
    end else begin
      r_instr      <= 32'd0;
      r_pcplusfour <= 32'd0;
      r_valid      <= 1'b0;
    end
  end

  assign imemREN        = ~RST & ~r_fetch_halted;
  assign imemaddr       = r_pc;
  assign instr_out      = r_instr;
  assign pcplusfour_out = r_pcplusfour;
  assign valid_out      = r_valid;
  assign fetch_cnt      = r_fetch_cnt;

endmodule
